muldiv_sched: RTL

Sequencing controller for the execute-stage multiply/divide resources. It accepts one mult/div operation from EX and registers its operands. It then runs either the pipelined multiplier (a fixed number of clock-enabled cycles) or the iterative divider (valid/ready handshake), and holds the 64-bit {hi,lo} result until the pipeline advances. It produces the single EX stall for both units, drives their clear and reset inputs on flush, and can optionally short-circuit repeated identical operations.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_result_cache.sv | 41 ++++
 rtl/muldiv_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the mult/div sequencer
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    // op is {is_div, is_signed}
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int MUL_LAT_DEFAULT = 9;

    // Identity of an operation, used to recognise repeats
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_key_t;

    function automatic op_key_t make_key(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        op_key_t k;
        k.op = op;
        k.a  = a;
        k.b  = b;
        return k;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - bundle between the sequencer and the multiplier/divider units
interface muldiv_if;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic        mul_ce;
    logic        mul_sign;
    logic        mul_sclr;
    logic [63:0] mul_p;
    logic        div_opn_valid;
    logic        div_sign;
    logic        div_rst;
    logic        div_res_valid;
    logic        div_res_ready;
    logic [63:0] div_result;

    // Sequencer side
    modport master (
        output opnd_a, opnd_b,
        output mul_ce, mul_sign, mul_sclr,
        input  mul_p,
        output div_opn_valid, div_sign, div_rst, div_res_ready,
        input  div_res_valid, div_result
    );

    // Arithmetic unit side
    modport slave (
        input  opnd_a, opnd_b,
        input  mul_ce, mul_sign, mul_sclr,
        output mul_p,
        input  div_opn_valid, div_sign, div_rst, div_res_ready,
        output div_res_valid, div_result
    );
endinterface

// File: rtl/muldiv_result_cache.sv
// rtl/muldiv_result_cache.sv - one-entry last-result cache, used under MULDIV_RESULT_CACHE_EN
module muldiv_result_cache
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // lookup port
    input  logic [1:0]  i_lk_op,
    input  logic [31:0] i_lk_a,
    input  logic [31:0] i_lk_b,
    output logic        o_lk_hit,
    output logic [63:0] o_lk_res,
    // update port
    input  logic        i_up_en,
    input  logic [1:0]  i_up_op,
    input  logic [31:0] i_up_a,
    input  logic [31:0] i_up_b,
    input  logic [63:0] i_up_res
);

    logic        r_vld;
    op_key_t     r_key;
    logic [63:0] r_res;

    // Record the most recently completed operation; only reset drops validity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_key <= '0;
            r_res <= '0;
        end else if (i_up_en) begin
            r_vld <= 1'b1;
            r_key <= make_key(i_up_op, i_up_a, i_up_b);
            r_res <= i_up_res;
        end
    end

    assign o_lk_hit = r_vld && (r_key == make_key(i_lk_op, i_lk_a, i_lk_b));
    assign o_lk_res = r_res;

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - EX mult/div sequencer; MULDIV_RESULT_CACHE_EN adds a repeat-op cache
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushE,
    input  logic        flush_exceptionM,
    input  logic        stallM,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        muldiv_stallE,
    output logic        result_valid,
    output logic [63:0] result,
    muldiv_if.master    unit
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_MUL   = S_MUL;
    localparam logic [1:0] ST_DIV   = S_DIV;
    localparam logic [1:0] ST_HOLD  = S_HOLD;
    localparam logic [3:0] LAT_LAST = 4'(MUL_LAT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_op_q;
    logic [31:0] r_opnd_a;
    logic [31:0] r_opnd_b;
    logic [63:0] r_res_q;

    logic [1:0]  w_state_nxt;
    logic        w_in_idle;
    logic        w_in_mul;
    logic        w_in_div;
    logic        w_in_hold;
    logic        w_hit;
    logic        w_cache_hit;
    logic [63:0] w_cache_res;
    logic        w_accept;
    logic        w_done;
    logic [63:0] w_done_res;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_in_mul  = (r_state == ST_MUL);
    assign w_in_div  = (r_state == ST_DIV);
    assign w_in_hold = (r_state == ST_HOLD);

`ifdef MULDIV_RESULT_CACHE_EN
    muldiv_result_cache u_cache (
        .clk      (clk),
        .rst      (rst),
        .i_lk_op  (op),
        .i_lk_a   (src_a),
        .i_lk_b   (src_b),
        .o_lk_hit (w_cache_hit),
        .o_lk_res (w_cache_res),
        .i_up_en  (w_done),
        .i_up_op  (r_op_q),
        .i_up_a   (r_opnd_a),
        .i_up_b   (r_opnd_b),
        .i_up_res (w_done_res)
    );
`else
    assign w_cache_hit = 1'b0;
    assign w_cache_res = '0;
`endif

    // A hit answers the EX op straight from the cache without leaving IDLE
    assign w_hit    = w_in_idle & op_valid & w_cache_hit;
    assign w_accept = w_in_idle & op_valid & ~flushE & ~w_hit;

    // Completion of either unit; a flush in the same cycle discards the result
    assign w_done = ~flushE & ((w_in_mul & (r_cnt == LAT_LAST)) |
                               (w_in_div & unit.div_res_valid));
    assign w_done_res = w_in_mul ? unit.mul_p : unit.div_result;

    // Next-state decode; flushE overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                  w_state_nxt = op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (r_cnt == LAT_LAST)         w_state_nxt = ST_HOLD;
            ST_DIV:  if (unit.div_res_valid)        w_state_nxt = ST_HOLD;
            ST_HOLD: if (!stallM)                   w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
        if (flushE) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture op and operands on accept; count multiplier CE cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op_q   <= '0;
            r_opnd_a <= '0;
            r_opnd_b <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op_q   <= op;
            r_opnd_a <= src_a;
            r_opnd_b <= src_b;
        end else if (w_in_mul) begin
            r_cnt    <= r_cnt + 4'd1;
        end
    end

    // Hold the finished {hi, lo} until the pipeline consumes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_q <= '0;
        end else if (w_done) begin
            r_res_q <= w_done_res;
        end
    end

    assign muldiv_stallE = ((w_in_idle & op_valid & ~w_hit) | w_in_mul | w_in_div) &
                           ~flush_exceptionM;
    assign result_valid  = w_in_hold | w_hit;
    assign result        = w_in_hold ? r_res_q : (w_hit ? w_cache_res : 64'd0);

    assign unit.opnd_a        = r_opnd_a;
    assign unit.opnd_b        = r_opnd_b;
    assign unit.mul_ce        = w_in_mul;
    assign unit.mul_sign      = w_in_mul & r_op_q[0];
    assign unit.mul_sclr      = flushE;
    assign unit.div_opn_valid = w_in_div;
    assign unit.div_sign      = w_in_div & r_op_q[0];
    assign unit.div_rst       = flushE;
    assign unit.div_res_ready = w_in_div & unit.div_res_valid;

endmodule
